mux_self_test: RTL and testbench

- Sequential tester that sits on both sides of the 2-to-1 gate-level mux stage on the DE1-SoC lab board.
- Drives the mux data inputs x, y and select s through all 8 input combinations at a programmable rate.
- Samples the mux output m after each settle interval and compares it against the expected value (s ? y : x).
- Reports busy, done, pass and a saturating error count on LEDR.

---
 rtl/mux_self_test.sv | 130 +++++++++++++
 tb/tb_mux_self_test.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_self_test.sv
// mux_self_test
// Sequential tester for a 2-to-1 mux stage. It steps the mux inputs
// {s,y,x} through all 8 combinations. Each vector is held for RATE_DIV
// cycles, then the mux output is sampled for one cycle and compared
// against s ? y : x.
//
// Ports:
//   clock     - system clock
//   reset     - synchronous, active-high reset
//   start     - level input; a rising edge launches a run from IDLE or DONE
//   pause     - while high, freezes the settle divider during APPLY
//   m_in      - mux output under test
//   x_out     - mux data input x (vector[0])
//   y_out     - mux data input y (vector[1])
//   s_out     - mux select s     (vector[2])
//   vector    - current vector index {s,y,x}
//   busy      - high in APPLY or CHECK
//   done      - high in DONE
//   pass      - high in DONE when no mismatches were seen
//   err_count - saturating mismatch count
module mux_self_test #(
  parameter int RATE_DIV = 50000000,
  parameter int ERR_W    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             m_in,
  output logic             x_out,
  output logic             y_out,
  output logic             s_out,
  output logic [2:0]       vector,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(RATE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q,  state_d;
  logic [2:0]       vector_q, vector_d;
  logic [DIV_W-1:0] div_q,    div_d;
  logic [ERR_W-1:0] err_q,    err_d;
  logic             start_q;

  logic start_rise;
  logic expected;

  assign start_rise = start & ~start_q;
  // Expected value comes from the registered vector only, so m_in never
  // reaches an output combinationally.
  assign expected   = vector_q[2] ? vector_q[1] : vector_q[0];

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    div_d    = div_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          state_d  = S_APPLY;
          vector_d = 3'd0;
          div_d    = DIV_LOAD;
          err_d    = '0;
        end
      end
      S_APPLY: begin
        if (!pause) begin
          if (div_q == '0) begin
            state_d = S_CHECK;
          end else begin
            div_d = div_q - DIV_ONE;
          end
        end
      end
      S_CHECK: begin
        // Saturate rather than wrap so a heavily broken mux never reads as clean.
        if ((m_in != expected) && (err_q != '1)) begin
          err_d = err_q + ERR_ONE;
        end
        if (vector_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          vector_d = vector_q + 3'd1;
          div_d    = DIV_LOAD;
          state_d  = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      vector_q <= 3'd0;
      div_q    <= '0;
      err_q    <= '0;
      // Reset high so a start level held through reset release is not an edge.
      start_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      vector_q <= vector_d;
      div_q    <= div_d;
      err_q    <= err_d;
      start_q  <= start;
    end
  end

  assign vector    = vector_q;
  assign x_out     = vector_q[0];
  assign y_out     = vector_q[1];
  assign s_out     = vector_q[2];
  assign busy      = (state_q == S_APPLY) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = (state_q == S_DONE) && (err_q == '0);
  assign err_count = err_q;

endmodule

// File: tb/tb_mux_self_test.sv
module tb_mux_self_test;

  localparam int RD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, pause, m_in;
  logic       x_out, y_out, s_out, busy, done, pass;
  logic [2:0] vector;
  logic [3:0] err_count;

  logic       start2, m_in2;
  logic       x2, y2, s2, busy2, done2, pass2;
  logic [2:0] vector2;
  logic [1:0] err2;

  int checks = 0;
  int errors = 0;

  // m_in behaviour: 0 golden, 1 stuck-0, 2 stuck-1, 3 inverted
  int mode;

  mux_self_test #(.RATE_DIV(RD), .ERR_W(4)) dut (
    .clock(clk), .reset(reset), .start(start), .pause(pause), .m_in(m_in),
    .x_out(x_out), .y_out(y_out), .s_out(s_out), .vector(vector),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
  );

  mux_self_test #(.RATE_DIV(RD), .ERR_W(2)) dut2 (
    .clock(clk), .reset(reset), .start(start2), .pause(1'b0), .m_in(m_in2),
    .x_out(x2), .y_out(y2), .s_out(s2), .vector(vector2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
  );

  always_comb begin
    case (mode)
      1:       m_in = 1'b0;
      2:       m_in = 1'b1;
      3:       m_in = ~(s_out ? y_out : x_out);
      default: m_in = s_out ? y_out : x_out;
    endcase
  end
  assign m_in2 = ~(s2 ? y2 : x2);

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  typedef struct {
    int mode;
    int pause_vec;   // vector during whose APPLY pause is held 10 cycles, -1 none
    int retrig_vec;  // vector during whose APPLY start toggles 0->1, -1 none
    int exp_busy;
    int exp_err;
    int exp_pass;
  } run_t;

  run_t runs[6];

  int busy_cnt;
  int hold_cnt[8];
  int drive_bad;

  // Launch a run with a start pulse and watch it until done or budget.
  task automatic do_run(input run_t r);
    int pause_left;
    int it;
    busy_cnt   = 0;
    drive_bad  = 0;
    pause_left = 10;
    for (int v = 0; v < 8; v++) hold_cnt[v] = 0;
    mode = r.mode;
    @(negedge clk);
    start = 1'b1;
    it = 0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      if (it > 2000) begin
        errors++;
        $display("FAIL run_timeout actual=%0d required=done", it);
        break;
      end
      if (busy) begin
        busy_cnt++;
        hold_cnt[vector]++;
      end
      if ({s_out, y_out, x_out} != vector) drive_bad++;
      start = 1'b0;
      if (r.retrig_vec >= 0 && int'(vector) == r.retrig_vec) begin
        if (hold_cnt[vector] == 1) start = 1'b1;
      end
      pause = 1'b0;
      if (r.pause_vec >= 0 && int'(vector) == r.pause_vec &&
          hold_cnt[vector] >= 1 && pause_left > 0) begin
        pause = 1'b1;
        pause_left--;
      end
      it++;
    end
    start = 1'b0;
    pause = 1'b0;
  endtask

  initial begin
    runs[0] = '{0, -1, -1, 40, 0, 1};  // golden
    runs[1] = '{1, -1, -1, 40, 4, 0};  // stuck 0: vectors 1,3,6,7
    runs[2] = '{2, -1, -1, 40, 4, 0};  // stuck 1: vectors 0,2,4,5
    runs[3] = '{3, -1, -1, 40, 8, 0};  // inverted: all 8
    runs[4] = '{0,  2, -1, 50, 0, 1};  // pause 10 cycles in vector 2 APPLY
    runs[5] = '{0, -1,  3, 40, 0, 1};  // start re-rise mid-run ignored

    mode   = 0;
    reset  = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    pause  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_vector", int'(vector), 0);
    check("reset_xys", int'({s_out, y_out, x_out}), 0);
    check("reset_busy_done_pass", int'({busy, done, pass}), 0);
    check("reset_err", int'(err_count), 0);

    for (int i = 0; i < 6; i++) begin
      do_run(runs[i]);
      check($sformatf("run%0d_busy_cycles", i), busy_cnt, runs[i].exp_busy);
      check($sformatf("run%0d_done", i), int'(done), 1);
      check($sformatf("run%0d_busy_after", i), int'(busy), 0);
      check($sformatf("run%0d_err", i), int'(err_count), runs[i].exp_err);
      check($sformatf("run%0d_pass", i), int'(pass), runs[i].exp_pass);
      check($sformatf("run%0d_final_vec", i), int'({vector, s_out, y_out, x_out}), 8'h3F);
      check($sformatf("run%0d_drive", i), drive_bad, 0);
      // 4 APPLY + 1 CHECK per vector; the paused vector adds 10 APPLY cycles
      for (int v = 0; v < 8; v++)
        check($sformatf("run%0d_hold_v%0d", i, v), hold_cnt[v],
              (v == runs[i].pause_vec) ? 15 : 5);
      $display("run %0d mode=%0d busy=%0d err=%0d pass=%0d", i, runs[i].mode,
               busy_cnt, err_count, pass);
    end

    // Restart from DONE (previous run passed): done/pass drop on the rise edge.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_done", int'(done), 0);
    check("restart_pass", int'(pass), 0);
    check("restart_vector", int'(vector), 0);
    check("restart_busy", int'(busy), 1);
    $display("restart from DONE busy=%0d vector=%0d", busy, vector);

    // Reset mid-run at vector 5 with start held high through and after reset.
    begin
      int it = 0;
      while (vector != 3'd5 && it < 200) begin
        @(negedge clk);
        it++;
      end
      check("reach_vec5", int'(vector), 5);
    end
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_vector", int'(vector), 0);
    check("midreset_xys", int'({s_out, y_out, x_out}), 0);
    check("midreset_flags", int'({busy, done, pass}), 0);
    check("midreset_err", int'(err_count), 0);
    repeat (3) @(negedge clk);
    check("midreset_no_launch", int'(busy), 0);
    $display("mid-run reset vector=%0d busy=%0d", vector, busy);
    start = 1'b0;
    @(negedge clk);
    do_run(runs[0]);
    check("postreset_busy_cycles", busy_cnt, 40);
    check("postreset_hold_v0", hold_cnt[0], 5);
    check("postreset_pass", int'(pass), 1);
    $display("post-reset run busy=%0d pass=%0d", busy_cnt, pass);

    // ERR_W=2 instance with an inverting mux: 8 mismatches saturate at 3.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    begin
      int it = 0;
      while (!done2 && it < 200) begin
        @(negedge clk);
        it++;
      end
      check("sat_done", int'(done2), 1);
    end
    check("sat_err", int'(err2), 3);
    check("sat_pass", int'(pass2), 0);
    $display("ERR_W=2 inverted run err=%0d pass=%0d", err2, pass2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
